// File: rtl/gnt_mux_pkg.sv
// gnt_mux_pkg: shared state encodings, agent indices and default widths for gnt_data_mux
package gnt_mux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] AGT0 = 2'd0;
   localparam logic [1:0] AGT1 = 2'd1;
   localparam logic [1:0] AGT2 = 2'd2;
   localparam logic [1:0] AGT3 = 2'd3;

   localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/gnt_mux_out_reg.sv
// gnt_mux_out_reg: single-entry valid/data/src output register with load/unload handshake
module gnt_mux_out_reg
   import gnt_mux_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              unload,
   input  logic [DATA_W-1:0] load_data,
   input  logic [1:0]        load_src,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [1:0]        src
);

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         src   <= AGT0;
      end else begin
         valid <= load | (valid & ~unload);
         if (load) begin
            data <= load_data;
            src  <= load_src;
         end
      end
   end

endmodule

// File: rtl/gnt_data_mux.sv
// gnt_data_mux: steers the granted agent's beats onto one registered target port with burst cap and grant checks.
// Optional stall watchdog enabled by defining GNT_MUX_WDOG_EN.
module gnt_data_mux
   import gnt_mux_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter int MAX_BURST = 16
`ifdef GNT_MUX_WDOG_EN
   ,
   parameter int WDOG_CYCLES = 64
`endif
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           gnt_0,
   input  logic                           gnt_1,
   input  logic                           gnt_2,
   input  logic                           gnt_3,
   input  logic                           valid_0,
   input  logic                           valid_1,
   input  logic                           valid_2,
   input  logic                           valid_3,
   input  logic [DATA_W-1:0]              data_0,
   input  logic [DATA_W-1:0]              data_1,
   input  logic [DATA_W-1:0]              data_2,
   input  logic [DATA_W-1:0]              data_3,
   output logic                           ready_0,
   output logic                           ready_1,
   output logic                           ready_2,
   output logic                           ready_3,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [1:0]                     out_src,
   input  logic                           out_ready,
   output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt,
   output logic                           burst_done,
   output logic                           onehot_err,
   output logic                           wdog_err
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   state_t            state, state_n;
   logic [1:0]        src, src_n;
   logic [3:0]        g, v, rdy;
   logic [DATA_W-1:0] sel_data;
   logic              one, viol, viol_d, gs, vs, rdy_src, acc;

   assign g = {gnt_3, gnt_2, gnt_1, gnt_0};
   assign v = {valid_3, valid_2, valid_1, valid_0};
   assign {ready_3, ready_2, ready_1, ready_0} = rdy;
   assign burst_done = beat_cnt == CNT_MAX;

   always_comb begin
      one      = $countones(g) == 1;
      gs       = g[src];
      vs       = v[src];
      src_n    = g[3] ? AGT3 : g[2] ? AGT2 : g[1] ? AGT1 : AGT0;
      sel_data = src == AGT0 ? data_0 : src == AGT1 ? data_1 : src == AGT2 ? data_2 : data_3;
      // once a source is owned, any foreign grant is a violation, including while draining
      viol     = state == IDLE ? $countones(g) > 1 : |(g & ~(4'b0001 << src));
      rdy_src  = state == XFER && gs && !burst_done && (!out_valid || out_ready) && !viol;
      acc      = rdy_src && vs;
      rdy      = rdy_src ? 4'b0001 << src : 4'b0000;
      state_n  = (state == IDLE && one)                          ? XFER  :
                 (state == XFER && !gs)                          ? DRAIN :
                 (state == DRAIN && (!out_valid || out_ready))   ? IDLE  : state;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         src        <= AGT0;
         beat_cnt   <= '0;
         viol_d     <= 1'b0;
         onehot_err <= 1'b0;
      end else begin
         state      <= state_n;
         viol_d     <= viol;
         onehot_err <= viol & ~viol_d;
         if (state == IDLE && one) begin
            src      <= src_n;
            beat_cnt <= '0;
         end else if (acc) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   gnt_mux_out_reg #(.DATA_W(DATA_W)) u_out_reg (
      .clock     (clock),
      .reset     (reset),
      .load      (acc),
      .unload    (out_ready),
      .load_data (sel_data),
      .load_src  (src),
      .valid     (out_valid),
      .data      (out_data),
      .src       (out_src)
   );

`ifdef GNT_MUX_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

   logic [WD_W-1:0] stall_cnt;
   logic            stall;

   assign stall = out_valid && !out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         wdog_err  <= 1'b0;
      end else begin
         stall_cnt <= !stall ? '0 : stall_cnt == WD_MAX ? stall_cnt : stall_cnt + 1'b1;
         wdog_err  <= wdog_err | (stall && stall_cnt == WD_MAX - 1'b1);
      end
   end
`else
   assign wdog_err = 1'b0;
`endif

endmodule
